// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 encodings for RV32I
// loads and stores, FSM state encodings and the byte-enable width.
// This package holds the definitions that the core's riscv_def header
// provides for the rest of the pipeline.
package load_store_unit_pkg;

  localparam int BE_WIDTH = 4;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // LSU FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the load/store unit (the lsu_align block).
//   Request side : mem_read/mem_write/funct3/offset/store_data in,
//                  byte enables, lane-replicated write data and the
//                  illegal/misaligned fault flag out.
//   Response side: rsp_funct3/rsp_offset (latched with the request) and
//                  the raw read word in, extended load value out.
module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  fault,
  input  logic [2:0]            rsp_funct3,
  input  logic [1:0]            rsp_offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] load_value
);

  function automatic logic [DATA_WIDTH-1:0] sext8(input logic [7:0] v);
    return {{(DATA_WIDTH-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext8(input logic [7:0] v);
    return {{(DATA_WIDTH-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){1'b0}}, v};
  endfunction

  logic                  legal_f3;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] rsp_shifted;

  // Size is carried in funct3[1:0] for both loads and stores; byte and
  // halfword data are replicated so the memory only needs the enables.
  always_comb begin
    be    = '0;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    if (mem_write)
      legal_f3 = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else
      legal_f3 = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    fault = (mem_read || mem_write) &&
            ((mem_read && mem_write) || !legal_f3 || misaligned);
  end

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    rsp_shifted = rdata >> {rsp_offset, 3'b000};
    case (rsp_funct3)
      F3_LB:   load_value = sext8(rsp_shifted[7:0]);
      F3_LH:   load_value = sext16(rsp_shifted[15:0]);
      F3_LBU:  load_value = zext8(rsp_shifted[7:0]);
      F3_LHU:  load_value = zext16(rsp_shifted[15:0]);
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage sitting directly after the ALU. Takes the effective
// address, store data and funct3, runs a req/gnt/rvalid transaction on the
// data-memory port and stalls the core until the access completes.
//   Core side  : clk, rst (sync, active-low), mem_read, mem_write, funct3,
//                alu_result, store_data in; lsu_stall, lsu_done, lsu_fault,
//                load_data (registered, extended) out.
//   Memory side: dmem_req, dmem_we, dmem_addr (word aligned), dmem_be,
//                dmem_wdata out; dmem_gnt, dmem_rvalid, dmem_rdata in.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic                  lsu_fault,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [BE_WIDTH-1:0]   dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  capture;
  logic                  load_en;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BE_WIDTH-1:0]   req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [1:0]            req_offset;

  logic [BE_WIDTH-1:0]   align_be;
  logic [DATA_WIDTH-1:0] align_wdata;
  logic                  align_fault;
  logic [DATA_WIDTH-1:0] load_value;

  load_store_unit_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .offset     (alu_result[1:0]),
    .store_data (store_data),
    .be         (align_be),
    .wdata      (align_wdata),
    .fault      (align_fault),
    .rsp_funct3 (req_funct3),
    .rsp_offset (req_offset),
    .rdata      (dmem_rdata),
    .load_value (load_value)
  );

  // Inputs are only sampled in IDLE, so the instruction still presented
  // during DONE cannot start a second access.
  always_comb begin
    state_next = state;
    lsu_stall  = 1'b0;
    lsu_done   = 1'b0;
    lsu_fault  = 1'b0;
    dmem_req   = 1'b0;
    capture    = 1'b0;
    load_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          if (align_fault) begin
            lsu_fault = 1'b1;
          end else begin
            capture    = 1'b1;
            lsu_stall  = 1'b1;
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        dmem_req  = 1'b1;
        lsu_stall = 1'b1;
        if (dmem_gnt)
          state_next = req_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        lsu_stall = 1'b1;
        if (dmem_rvalid) begin
          load_en    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        lsu_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_addr   <= '0;
      req_be     <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      req_funct3 <= '0;
      req_offset <= '0;
      load_data  <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        req_addr   <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
        req_be     <= align_be;
        req_wdata  <= align_wdata;
        req_we     <= mem_write;
        req_funct3 <= funct3;
        req_offset <= alu_result[1:0];
      end
      if (load_en)
        load_data <= load_value;
    end
  end

  assign dmem_we    = req_we;
  assign dmem_addr  = req_addr;
  assign dmem_be    = req_be;
  assign dmem_wdata = req_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_fault;
  logic [31:0] load_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_tests;
  int n_fail;
  int done_count;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .lsu_stall   (lsu_stall),
    .lsu_done    (lsu_done),
    .lsu_fault   (lsu_fault),
    .load_data   (load_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every completion pulse pops one expected load_data.
  always @(negedge clk) begin
    if (lsu_done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check(tag_q.pop_front(), load_data, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1 with the unit in IDLE; returns at posedge+1 after DONE.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input int gnt_delay,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_ld, input int exp_stall,
                        input int exp_cycles);
    int  cycles;
    int  stalls;
    int  reqs;
    bit  done;
    bit  granted;
    cycles = 0; stalls = 0; reqs = 0; done = 0; granted = 0;
    mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; store_data = sdata;
    exp_q.push_back(exp_ld);
    tag_q.push_back({tag, "_load_data"});
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (lsu_stall) stalls++;
      if (dmem_req) begin
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        check({tag, "_we"}, {31'd0, dmem_we}, {31'd0, wr});
        if (wr) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        if (reqs == gnt_delay) begin
          dmem_gnt = 1'b1;
          granted  = 1'b1;
        end
        reqs++;
      end else if (lsu_stall && granted && rd) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
      if (lsu_done) begin
        done = 1;
        check({tag, "_done_stall"}, {31'd0, lsu_stall}, 32'd0);
      end
      @(posedge clk);
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
    end
    check({tag, "_completed"}, {31'd0, done}, 32'd1);
    check({tag, "_cycles"}, cycles, exp_cycles);
    check({tag, "_stall_cycles"}, stalls, exp_stall);
    check({tag, "_req_cycles"}, reqs, gnt_delay + 1);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic fault_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] keep_ld);
    mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; store_data = 32'h5555_AAAA;
    @(negedge clk);
    check({tag, "_fault"}, {31'd0, lsu_fault}, 32'd1);
    check({tag, "_stall"}, {31'd0, lsu_stall}, 32'd0);
    check({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check({tag, "_fault_clear"}, {31'd0, lsu_fault}, 32'd0);
      check({tag, "_no_req"}, {31'd0, dmem_req}, 32'd0);
      check({tag, "_load_kept"}, load_data, keep_ld);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int done_before;
    n_tests = 0; n_fail = 0; done_count = 0;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    alu_result = '0; store_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_load_data", load_data, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, lsu_stall}, 32'd0);
    check("rst_done", {31'd0, lsu_done}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Stores leave load_data alone; grant after two wait cycles.
    run_op("sw_100", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0,
           32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 4, 5);
    run_op("lb_203", 1, 0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233,
           32'h200, 4'b1000, 32'h0, 32'hFFFFFF80, 3, 4);
    run_op("lbu_203", 1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h80112233,
           32'h200, 4'b1000, 32'h0, 32'h00000080, 3, 4);
    run_op("lhu_202", 1, 0, 3'b101, 32'h202, 32'h0, 0, 32'hBEEF1234,
           32'h200, 4'b1100, 32'h0, 32'h0000BEEF, 3, 4);
    run_op("lh_202", 1, 0, 3'b001, 32'h202, 32'h0, 0, 32'hBEEF1234,
           32'h200, 4'b1100, 32'h0, 32'hFFFFBEEF, 3, 4);
    run_op("sh_202", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 32'h0,
           32'h200, 4'b1100, 32'hABCDABCD, 32'hFFFFBEEF, 2, 3);
    run_op("sb_101", 0, 1, 3'b000, 32'h101, 32'h00000077, 0, 32'h0,
           32'h100, 4'b0010, 32'h77777777, 32'hFFFFBEEF, 2, 3);
    run_op("lw_104", 1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h13579BDF,
           32'h104, 4'b1111, 32'h0, 32'h13579BDF, 4, 5);
    run_op("lb_001_pos", 1, 0, 3'b000, 32'h001, 32'h0, 0, 32'h00007F00,
           32'h000, 4'b0010, 32'h0, 32'h0000007F, 3, 4);

    fault_op("lw_misaligned", 1, 0, 3'b010, 32'h102, 32'h0000007F);
    fault_op("ld_f3_011", 1, 0, 3'b011, 32'h100, 32'h0000007F);
    fault_op("rd_and_wr", 1, 1, 3'b010, 32'h100, 32'h0000007F);
    fault_op("lh_odd", 1, 0, 3'b001, 32'h201, 32'h0000007F);
    fault_op("st_f3_100", 0, 1, 3'b100, 32'h100, 32'h0000007F);

    // Back-to-back: next instruction appears right after each DONE.
    done_before = done_count;
    run_op("b2b_sw", 0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 32'h0,
           32'h10, 4'b1111, 32'hCAFEF00D, 32'h0000007F, 2, 3);
    run_op("b2b_lw", 1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hCAFEF00D,
           32'h10, 4'b1111, 32'h0, 32'hCAFEF00D, 3, 4);
    check("b2b_done_pulses", done_count - done_before, 32'd2);

    // Reset while a load waits for its response.
    done_before = done_count;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h300;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid_req", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    rst = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    check("rstmid_wait_stall", {31'd0, lsu_stall}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    check("rstmid_req_low", {31'd0, dmem_req}, 32'd0);
    check("rstmid_stall_low", {31'd0, lsu_stall}, 32'd0);
    check("rstmid_load_zero", load_data, 32'd0);
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_load_still_zero", load_data, 32'd0);
      check("rstmid_idle_req", {31'd0, dmem_req}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("rstmid_no_done", done_count - done_before, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
